// File: rtl/load_store_unit_if.sv
// Request/response and DataMemory signals of the load/store unit.
// slave is the unit's own view; master is the CPU-plus-memory environment driving it.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_error;
  logic [31:0]           resp_rdata;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_writeData;
  logic                  mem_memWrite;
  logic                  mem_memRead;
  logic [31:0]           mem_readData;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_readData,
    output req_ready, resp_valid, resp_error, resp_rdata,
    output mem_address, mem_writeData, mem_memWrite, mem_memRead
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_readData,
    input  req_ready, resp_valid, resp_error, resp_rdata,
    input  mem_address, mem_writeData, mem_memWrite, mem_memRead
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide DataMemory; sub-word stores use read-modify-write.
// Latency: loads and word stores 2 cycles, sub-word stores 3, errors 1; one request in flight.
module load_store_unit #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic             clock,
  input  logic             reset,
  load_store_unit_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rword_q;
  logic                  error_q;
  logic [31:0]           rdata_q;
  logic                  req_bad;
  logic [31:0]           merged;

  assign req_bad = (bus.req_size == 2'b11)
                 || (bus.req_size == SZ_HALF && bus.req_addr[0])
                 || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Lane replace of the word fetched in READ; word stores ignore it.
  always_comb begin
    merged = rword_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'd0;
      rword_q    <= 32'd0;
      error_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q     <= bus.req_addr;
            write_q    <= bus.req_write;
            size_q     <= bus.req_size;
            unsigned_q <= bus.req_unsigned;
            wdata_q    <= bus.req_wdata;
            error_q    <= req_bad;
            if (req_bad) begin
              rdata_q <= 32'd0;
              state   <= RESP;
            end else if (bus.req_write && bus.req_size == SZ_WORD) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          rword_q <= bus.mem_readData;
          if (write_q) begin
            state <= WRITE;
          end else begin
            rdata_q <= load_extend(bus.mem_readData, size_q, addr_q[1:0], unsigned_q);
            state   <= RESP;
          end
        end
        WRITE: begin
          rdata_q <= 32'd0;
          state   <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.resp_valid    = (state == RESP);
  assign bus.resp_error    = error_q;
  assign bus.resp_rdata    = rdata_q;
  assign bus.mem_memRead   = (state == READ);
  assign bus.mem_memWrite  = (state == WRITE);
  assign bus.mem_address   = addr_q;
  assign bus.mem_writeData = (state == WRITE) ? merged : 32'd0;
endmodule
